// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  wren;
    logic                  is_load;
    logic                  is_mem;
  } shadow_entry_t;

  localparam shadow_entry_t BUBBLE = '0;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  function automatic logic rd_live(input logic wren, input logic [REG_ADDR_W-1:0] rd);
    return wren && (rd != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority comparator choosing the forwarding source for one ID-stage operand.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic                  rs_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wren,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_wren,
  output fwd_sel_e              sel
);

  always_comb begin
    // NOTE: default assigned first so no path leaves sel unassigned (no latch).
    sel = FWD_RF;
    if (rs_used) begin
      // The EX producer is one stage ahead of the consumer next cycle, so it wins.
      if (rd_live(ex_wren, ex_rd) && (ex_rd == rs_addr)) begin
        sel = FWD_MEM;
      end else if (rd_live(mem_wren, mem_rd) && (mem_rd == rs_addr)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for the 5-stage core.
// Define HAZARD_STAT_EN to add the o_stall_cnt stall/freeze cycle counter.
module hazard_fwd_ctrl
  import hazard_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_id_rd_wren,
  input  logic                  i_id_is_load,
  input  logic                  i_id_is_store,
  input  logic                  i_ex_br_taken,
  input  logic                  i_dmem_ready,
  output logic [1:0]            o_fwd_a_sel,
  output logic [1:0]            o_fwd_b_sel,
  output logic                  o_stall_pc,
  output logic                  o_stall_if_id,
  output logic                  o_flush_if_id,
  output logic                  o_flush_id_ex,
  output logic                  o_freeze
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);

  hz_state_e     state_q, state_d;
  shadow_entry_t ex_q, mem_q, wb_q, id_entry;
  fwd_sel_e      fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic          active_q;
  logic          freeze, load_use, branch, flush_id_ex;
  logic          rs1_hit, rs2_hit;

  assign id_entry = '{rd:      i_id_rd_addr,
                      wren:    i_id_rd_wren,
                      is_load: i_id_is_load,
                      is_mem:  i_id_is_load | i_id_is_store};

  assign freeze  = mem_q.is_mem & ~i_dmem_ready;
  assign rs1_hit = i_id_rs1_used & (i_id_rs1_addr == ex_q.rd);
  assign rs2_hit = i_id_rs2_used & (i_id_rs2_addr == ex_q.rd);
  assign load_use = ~freeze & ex_q.is_load & rd_live(ex_q.wren, ex_q.rd) & (rs1_hit | rs2_hit);
  // active_q keeps the branch input masked until the first edge after reset release.
  assign branch      = active_q & ~freeze & i_ex_br_taken;
  assign flush_id_ex = branch | load_use;

  assign o_freeze      = freeze;
  assign o_stall_pc    = load_use & ~branch;
  assign o_stall_if_id = load_use & ~branch;
  assign o_flush_if_id = branch;
  assign o_flush_id_ex = flush_id_ex;
  assign o_fwd_a_sel   = fwd_a_q;
  assign o_fwd_b_sel   = fwd_b_q;

  hazard_fwd_sel u_fwd_a (
    .rs_addr  (i_id_rs1_addr),
    .rs_used  (i_id_rs1_used),
    .ex_rd    (ex_q.rd),
    .ex_wren  (ex_q.wren),
    .mem_rd   (mem_q.rd),
    .mem_wren (mem_q.wren),
    .sel      (fwd_a_d)
  );

  hazard_fwd_sel u_fwd_b (
    .rs_addr  (i_id_rs2_addr),
    .rs_used  (i_id_rs2_used),
    .ex_rd    (ex_q.rd),
    .ex_wren  (ex_q.wren),
    .mem_rd   (mem_q.rd),
    .mem_wren (mem_q.wren),
    .sel      (fwd_b_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (freeze)       state_d = MEM_WAIT;
      MEM_WAIT: if (i_dmem_ready) state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      active_q <= 1'b0;
      ex_q     <= BUBBLE;
      mem_q    <= BUBBLE;
      wb_q     <= BUBBLE;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      // NOTE: non-blocking updates let the shift wb<-mem<-ex read pre-edge values.
      state_q  <= state_d;
      active_q <= 1'b1;
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        if (flush_id_ex) begin
          ex_q    <= BUBBLE;
          fwd_a_q <= FWD_RF;
          fwd_b_q <= FWD_RF;
        end else begin
          ex_q    <= id_entry;
          fwd_a_q <= fwd_a_d;
          fwd_b_q <= fwd_b_d;
        end
      end
    end
  end

  // The WB slot is tracked to mirror the pipeline; nothing downstream reads it yet.
  logic unused_wb;
  assign unused_wb = ^wb_q;

`ifdef HAZARD_STAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (o_stall_pc | freeze) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed, table-driven bench for hazard_fwd_ctrl plus freeze and reset sequences.
module tb_hazard_fwd_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, wr, ld, st, br, rdy;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_rs1_addr (rs1),
    .i_id_rs2_addr (rs2),
    .i_id_rs1_used (u1),
    .i_id_rs2_used (u2),
    .i_id_rd_addr  (rd),
    .i_id_rd_wren  (wr),
    .i_id_is_load  (ld),
    .i_id_is_store (st),
    .i_ex_br_taken (br),
    .i_dmem_ready  (rdy),
    .o_fwd_a_sel   (fwd_a),
    .o_fwd_b_sel   (fwd_b),
    .o_stall_pc    (stall_pc),
    .o_stall_if_id (stall_if_id),
    .o_flush_if_id (flush_if_id),
    .o_flush_id_ex (flush_id_ex),
    .o_freeze      (freeze)
`ifdef HAZARD_STAT_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, st, br, rdy;
    logic       stall, fl_if, fl_ex, frz;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic v1,
                              input logic v2, input logic [4:0] d, input logic w,
                              input logic l, input logic s, input logic b, input logic r,
                              input logic e_st, input logic e_fi, input logic e_fe,
                              input logic e_fz, input logic [1:0] e_a, input logic [1:0] e_b);
    vec_t v;
    v.rs1 = a1; v.rs2 = a2; v.u1 = v1; v.u2 = v2; v.rd = d;
    v.wr = w; v.ld = l; v.st = s; v.br = b; v.rdy = r;
    v.stall = e_st; v.fl_if = e_fi; v.fl_ex = e_fe; v.frz = e_fz;
    v.fa = e_a; v.fb = e_b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_st, input logic e_fi,
                            input logic e_fe, input logic e_fz, input logic [1:0] e_a,
                            input logic [1:0] e_b);
    check({tag, ".stall_pc"},    32'(stall_pc),    32'(e_st));
    check({tag, ".stall_if_id"}, 32'(stall_if_id), 32'(e_st));
    check({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(e_fi));
    check({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(e_fe));
    check({tag, ".freeze"},      32'(freeze),      32'(e_fz));
    check({tag, ".fwd_a"},       32'(fwd_a),       32'(e_a));
    check({tag, ".fwd_b"},       32'(fwd_b),       32'(e_b));
  endtask

  task automatic set_id(input logic [4:0] a1, input logic [4:0] a2, input logic v1,
                        input logic v2, input logic [4:0] d, input logic w,
                        input logic l, input logic s);
    rs1 = a1; rs2 = a2; u1 = v1; u2 = v2; rd = d; wr = w; ld = l; st = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs1 rs2 u1 u2 rd wr ld st br rdy | stall flif flex frz fa fb
    vecs[0]  = mk(5'd2,  5'd3, 1, 1, 5'd1,  1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[1]  = mk(5'd1,  5'd5, 1, 1, 5'd4,  1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[2]  = mk(5'd1,  5'd1, 1, 0, 5'd5,  1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00);
    vecs[3]  = mk(5'd8,  5'd5, 1, 1, 5'd7,  1, 0, 0, 0, 1, 1, 0, 1, 0, 2'b10, 2'b00);
    vecs[4]  = mk(5'd8,  5'd5, 1, 1, 5'd7,  1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[5]  = mk(5'd2,  5'd3, 1, 1, 5'd0,  1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10);
    vecs[6]  = mk(5'd0,  5'd0, 1, 1, 5'd9,  1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[7]  = mk(5'd9,  5'd0, 1, 0, 5'd10, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[8]  = mk(5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0, 1, 1, 0, 1, 1, 0, 2'b01, 2'b00);
    vecs[9]  = mk(5'd10, 5'd2, 1, 1, 5'd12, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[10] = mk(5'd0,  5'd0, 0, 0, 5'd0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00);

    rst_n = 1'b0;
    set_id(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    br = 1'b0; rdy = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 2'b00, 2'b00);
    check("reset.state", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_STAT_EN
    check("reset.cnt", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    next_cycle();

    // Main table: inputs present in ID, outputs checked mid-cycle.
    for (int i = 0; i < 11; i++) begin
      set_id(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
             vecs[i].rd, vecs[i].wr, vecs[i].ld, vecs[i].st);
      br = vecs[i].br; rdy = vecs[i].rdy;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].stall, vecs[i].fl_if, vecs[i].fl_ex,
                 vecs[i].frz, vecs[i].fa, vecs[i].fb);
      next_cycle();
    end

    // Freeze for 3 cycles with a consumer holding select b=10 in EX.
    set_id(5'd0, 5'd0, 0, 0, 5'd20, 1, 0, 0);
    @(negedge clk); check_outs("fzA", 0, 0, 0, 0, 2'b00, 2'b00);
    next_cycle();
    set_id(5'd20, 5'd0, 1, 0, 5'd21, 1, 1, 0);
    @(negedge clk); check_outs("fzB", 0, 0, 0, 0, 2'b00, 2'b00);
    next_cycle();
    set_id(5'd3, 5'd20, 1, 1, 5'd22, 1, 0, 0);
    @(negedge clk); check_outs("fzC", 0, 0, 0, 0, 2'b01, 2'b00);
`ifdef HAZARD_STAT_EN
    check("fzC.cnt", stall_cnt, 32'd1);
`endif
    next_cycle();
    set_id(5'd22, 5'd0, 1, 0, 5'd23, 1, 0, 0);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      br = (k == 1);
      @(negedge clk);
      check_outs($sformatf("fzD%0d", k), 0, 0, 0, 1, 2'b00, 2'b10);
      if (k == 1) check("fzD1.state", 32'(dut.state_q), 32'(MEM_WAIT));
      next_cycle();
    end
    br = 1'b0; rdy = 1'b1;
    @(negedge clk); check_outs("fzE", 0, 0, 0, 0, 2'b00, 2'b10);
`ifdef HAZARD_STAT_EN
    check("fzE.cnt", stall_cnt, 32'd4);
`endif
    next_cycle();
    set_id(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    @(negedge clk); check_outs("fzF", 0, 0, 0, 0, 2'b01, 2'b00);
    check("fzF.state", 32'(dut.state_q), 32'(RUN));
    next_cycle();

    // Reset while in MEM_WAIT, with branch and a stalled memory still asserted.
    set_id(5'd0, 5'd0, 0, 0, 5'd24, 1, 1, 0);
    next_cycle();
    set_id(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    next_cycle();
    rdy = 1'b0; br = 1'b1;
    @(negedge clk); check_outs("rsI", 0, 0, 0, 1, 2'b00, 2'b00);
    next_cycle();
    check("rsI.state", 32'(dut.state_q), 32'(MEM_WAIT));
    #3 rst_n = 1'b0;
    #1;
    check_outs("rs_low", 0, 0, 0, 0, 2'b00, 2'b00);
    check("rs_low.state", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_STAT_EN
    check("rs_low.cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("rs_rel", 0, 0, 0, 0, 2'b00, 2'b00);
    next_cycle();
    check_outs("rs_run", 0, 1, 1, 0, 2'b00, 2'b00);
    check("rs_run.state", 32'(dut.state_q), 32'(RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
